rej_eta_stream: RTL and testbench

REJ_ETA_STREAM -- requirements
Module: rej_eta_stream

---
 rtl/dilithium_pkg.sv | 18 +
 rtl/rej_eta_stream_if.sv | 24 ++
 rtl/eta_nibble_map.sv | 38 +++
 rtl/rej_eta_stream.sv | 117 +++++++++++
 tb/tb_rej_eta_stream.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dilithium_pkg.sv
// Shared constants and FSM state encoding for the eta rejection sampler.
// Holds the default run length, the eta select encodings and the state type.
package dilithium_pkg;

   localparam int N_DEFAULT = 256;

   localparam logic ETA2_SEL = 1'b0;
   localparam logic ETA4_SEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LO,
      HI,
      DONE
   } state_t;

endpackage

// File: rtl/rej_eta_stream_if.sv
// SHAKE byte stream in, signed coefficient stream out; both valid/ready.
// The slave modport is the sampler side, the master modport is the producer/consumer side.
interface rej_eta_stream_if #(
   parameter int COEF_W = 32,
   parameter int CNT_W  = 9
);
   logic                     in_valid;
   logic [7:0]               in_data;
   logic                     in_ready;
   logic                     out_valid;
   logic signed [COEF_W-1:0] out_coef;
   logic [CNT_W-1:0]         out_idx;
   logic                     out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_coef, out_idx
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_coef, out_idx
   );
endinterface

// File: rtl/eta_nibble_map.sv
// Combinational nibble -> (accept, coef) map for eta 2 / eta 4; zero latency, no handshake.
// The coefficient is produced at full COEF_W width, so sign extension comes from the arithmetic.
module eta_nibble_map
   import dilithium_pkg::*;
#(
   parameter int COEF_W = 32
) (
   input  logic [3:0]               t,
   input  logic                     eta_sel,
   output logic                     accept,
   output logic signed [COEF_W-1:0] coef
);
   localparam logic signed [COEF_W-1:0] K2   = COEF_W'(2);
   localparam logic signed [COEF_W-1:0] K4   = COEF_W'(4);
   localparam logic signed [COEF_W-1:0] K5   = COEF_W'(5);
   localparam logic signed [COEF_W-1:0] K205 = COEF_W'(205);

   logic signed [COEF_W-1:0] t_w;
   logic signed [COEF_W-1:0] quo;
   logic signed [COEF_W-1:0] rem;

   assign t_w = $signed({{(COEF_W-4){1'b0}}, t});
   // t mod 5 without a divider: (205*t)>>10 equals t/5 for t < 16
   assign quo = (t_w * K205) >>> 10;
   assign rem = t_w - K5 * quo;

   always_comb begin
      accept = 1'b0;
      coef   = '0;
      if (eta_sel == ETA2_SEL) begin
         accept = (t < 4'd15);
         coef   = K2 - rem;
      end else begin
         accept = (t < 4'd9);
         coef   = K4 - t_w;
      end
   end
endmodule

// File: rtl/rej_eta_stream.sv
// Rejection-samples SHAKE bytes into eta-bounded coefficients: 1 cycle byte-accept to out_valid, up to 3 cycles/byte.
// in_ready only in FETCH; an accepted nibble holds out_coef/out_idx until out_ready, stalling byte intake.
module rej_eta_stream
   import dilithium_pkg::*;
#(
   parameter int N      = N_DEFAULT,
   parameter int COEF_W = 32,
   parameter int CNT_W  = 9
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             eta_sel,
   input  logic [CNT_W-1:0] len,
   output logic [CNT_W-1:0] bytes_used,
   output logic             done,
   rej_eta_stream_if.slave  strm
);
   localparam logic [CNT_W-1:0] LEN_MAX = CNT_W'(N);

   state_t                   state;
   state_t                   state_nxt;
   logic                     eta_q;
   logic [CNT_W-1:0]         len_q;
   logic [CNT_W-1:0]         ctr;
   logic [CNT_W-1:0]         ctr_inc;
   logic [CNT_W-1:0]         len_clamp;
   logic [7:0]               byte_q;
   logic [3:0]               nib;
   logic                     nib_accept;
   logic signed [COEF_W-1:0] nib_coef;
   logic                     nib_phase;
   logic                     out_vld;
   logic                     load_run;
   logic                     take_byte;
   logic                     xfer;

   assign len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
   assign ctr_inc   = ctr + CNT_W'(1);
   assign nib_phase = (state == LO) || (state == HI);
   assign nib       = (state == HI) ? byte_q[7:4] : byte_q[3:0];

   eta_nibble_map #(
      .COEF_W (COEF_W)
   ) u_map (
      .t       (nib),
      .eta_sel (eta_q),
      .accept  (nib_accept),
      .coef    (nib_coef)
   );

   assign out_vld        = nib_phase && nib_accept;
   assign strm.out_valid = out_vld;
   assign strm.out_coef  = out_vld ? nib_coef : '0;
   assign strm.out_idx   = ctr;
   assign strm.in_ready  = (state == FETCH);
   assign done           = (state == DONE);

   always_comb begin
      state_nxt = state;
      load_run  = 1'b0;
      take_byte = 1'b0;
      xfer      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_run  = 1'b1;
               state_nxt = (len_clamp == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (strm.in_valid) begin
               take_byte = 1'b1;
               state_nxt = LO;
            end
         end
         LO, HI: begin
            if (!nib_accept) begin
               state_nxt = (state == LO) ? HI : FETCH;
            end else if (strm.out_ready) begin
               xfer = 1'b1;
               // Reaching len on a low nibble drops the high nibble of that byte
               if (ctr_inc == len_q) state_nxt = DONE;
               else                  state_nxt = (state == LO) ? HI : FETCH;
            end
         end
         DONE: begin
            if (!start) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         eta_q      <= 1'b0;
         len_q      <= '0;
         ctr        <= '0;
         bytes_used <= '0;
         byte_q     <= '0;
      end else begin
         state <= state_nxt;
         if (load_run) begin
            eta_q      <= eta_sel;
            len_q      <= len_clamp;
            ctr        <= '0;
            bytes_used <= '0;
         end
         if (take_byte) begin
            byte_q     <= strm.in_data;
            bytes_used <= bytes_used + CNT_W'(1);
         end
         if (xfer) ctr <= ctr_inc;
      end
   end
endmodule

// File: tb/tb_rej_eta_stream.sv
// Directed-vector bench for rej_eta_stream: expected coefficients are queued at stimulus time
// and a separate monitor pops them on every output transfer.
module tb_rej_eta_stream;
   import dilithium_pkg::*;

   typedef struct {
      int coef;
      int idx;
   } exp_t;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic       eta_sel;
   logic [8:0] len;
   logic [8:0] bytes_used;
   logic       done;

   int         n_cmp = 0;
   int         n_bad = 0;
   exp_t       sb[$];
   logic [7:0] bq[$];
   logic       stall_mode = 1'b0;

   rej_eta_stream_if #(.COEF_W(32), .CNT_W(9)) strm ();

   rej_eta_stream #(.N(256), .COEF_W(32), .CNT_W(9)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start      (start),
      .eta_sel    (eta_sel),
      .len        (len),
      .bytes_used (bytes_used),
      .done       (done),
      .strm       (strm.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_push(input int c, input int i);
      exp_t e;
      e.coef = c;
      e.idx  = i;
      sb.push_back(e);
   endtask

   // Scoreboard monitor and stall-stability checks
   logic        pend = 1'b0;
   logic [31:0] p_coef;
   logic [8:0]  p_idx;
   always @(negedge clock) begin
      if (!reset_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            chk("stall_valid", strm.out_valid, 1);
            chk("stall_coef", $signed(strm.out_coef), $signed(p_coef));
            chk("stall_idx", strm.out_idx, p_idx);
            chk("stall_in_ready", strm.in_ready, 0);
         end
         if (strm.out_valid && strm.out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL sb_unexpected: got coef %0d idx %0d, expected no output",
                        $signed(strm.out_coef), strm.out_idx);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("coef", $signed(strm.out_coef), e.coef);
               chk("idx", strm.out_idx, e.idx);
            end
         end
         pend   = strm.out_valid && !strm.out_ready;
         p_coef = strm.out_coef;
         p_idx  = strm.out_idx;
      end
   end

   // out_ready driver: always ready, or held low for 5 cycles on each output
   initial begin
      int  hold;
      logic v, r;
      hold = 0;
      strm.out_ready = 1'b1;
      forever begin
         @(negedge clock);
         v = strm.out_valid;
         r = strm.out_ready;
         @(posedge clock);
         #1;
         if (!stall_mode) begin
            strm.out_ready = 1'b1;
            hold = 0;
         end else if (v && !r) begin
            hold++;
            if (hold >= 5) strm.out_ready = 1'b1;
         end else begin
            strm.out_ready = 1'b0;
            hold = 0;
         end
      end
   end

   task automatic feed(input logic [7:0] b);
      int   cnt;
      logic acc;
      cnt = 0;
      strm.in_valid = 1'b1;
      strm.in_data  = b;
      do begin
         @(negedge clock);
         acc = strm.in_ready;
         @(posedge clock);
         #1;
         cnt++;
      end while (!acc && cnt < 200);
      strm.in_valid = 1'b0;
      if (!acc) chk("feed_timeout", 0, 1);
   endtask

   task automatic wait_done(input int limit);
      int c;
      c = 0;
      do begin
         @(negedge clock);
         c++;
      end while (!done && c < limit);
      chk("done", done, 1);
   endtask

   task automatic finish_run(input int exp_used);
      chk("bytes_used", bytes_used, exp_used);
      chk("sb_drained", sb.size(), 0);
      @(posedge clock);
      #1;
      start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("done_clear", done, 0);
   endtask

   task automatic run(input logic eta, input int ln, input int exp_used, input logic toggle);
      @(posedge clock);
      #1;
      eta_sel = eta;
      len     = ln[8:0];
      start   = 1'b1;
      for (int k = 0; k < bq.size(); k++) begin
         feed(bq[k]);
         if (toggle && k == 0) begin
            start = 1'b0;
            @(posedge clock);
            @(posedge clock);
            #1;
            start = 1'b1;
         end
      end
      wait_done(1000);
      finish_run(exp_used);
      bq.delete();
   endtask

   initial begin
      reset_n       = 1'b0;
      start         = 1'b0;
      eta_sel       = 1'b0;
      len           = '0;
      strm.in_valid = 1'b0;
      strm.in_data  = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_in_ready", strm.in_ready, 0);
      chk("rst_out_valid", strm.out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_bytes_used", bytes_used, 0);
      chk("rst_out_idx", strm.out_idx, 0);
      reset_n = 1'b1;

      // eta 4: 0x93 -> 1, 9 rejected; 0x21 -> 3; start toggled mid-run
      exp_push(1, 0); exp_push(3, 1);
      bq = '{8'h93, 8'h21};
      run(ETA4_SEL, 2, 2, 1'b1);

      // eta 2: 0xE7 -> 7 gives 0, 14 gives -2
      exp_push(0, 0); exp_push(-2, 1);
      bq = '{8'hE7};
      run(ETA2_SEL, 2, 1, 1'b0);

      // eta 2: 0xFF fully rejected; 0x03 -> -1, high nibble dropped
      exp_push(-1, 0);
      bq = '{8'hFF, 8'h03};
      run(ETA2_SEL, 1, 2, 1'b0);

      // eta 2: 10 -> 2, 9 -> -2, 3 -> -1, 4 -> -2
      exp_push(2, 0); exp_push(-2, 1); exp_push(-1, 2); exp_push(-2, 3);
      bq = '{8'h9A, 8'h43};
      run(ETA2_SEL, 4, 2, 1'b0);

      // eta 4 with out_ready stalled 5 cycles per output
      stall_mode = 1'b1;
      strm.out_ready = 1'b0;
      exp_push(2, 0); exp_push(-1, 1); exp_push(4, 2);
      bq = '{8'h52, 8'h80};
      run(ETA4_SEL, 3, 2, 1'b0);
      stall_mode = 1'b0;
      @(posedge clock);
      #1;

      // len 0: done without ever offering in_ready
      begin
         logic seen_rdy, done_by2;
         seen_rdy = 1'b0;
         done_by2 = 1'b0;
         eta_sel  = ETA4_SEL;
         len      = '0;
         start    = 1'b1;
         for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            if (strm.in_ready) seen_rdy = 1'b1;
            if (done) done_by2 = 1'b1;
         end
         chk("len0_done_2cyc", done_by2, 1);
         chk("len0_in_ready", seen_rdy, 0);
         finish_run(0);
      end

      // len 300 clamps to 256: 128 zero bytes yield 256 coefs of 4
      for (int i = 0; i < 256; i++) exp_push(4, i);
      for (int i = 0; i < 128; i++) bq.push_back(8'h00);
      run(ETA4_SEL, 300, 128, 1'b0);

      // reset after 10 coefs of a len-20 run
      for (int i = 0; i < 10; i++) exp_push(4, i);
      @(posedge clock);
      #1;
      eta_sel = ETA4_SEL;
      len     = 9'd20;
      start   = 1'b1;
      for (int k = 0; k < 5; k++) feed(8'h00);
      begin
         int c;
         c = 0;
         while (sb.size() != 0 && c < 200) begin
            @(negedge clock);
            c++;
         end
         chk("pre_reset_drained", sb.size(), 0);
      end
      @(posedge clock);
      #1;
      chk("pre_reset_bytes_used", bytes_used, 5);
      reset_n = 1'b0;
      #1;
      chk("arst_out_valid", strm.out_valid, 0);
      chk("arst_in_ready", strm.in_ready, 0);
      chk("arst_done", done, 0);
      chk("arst_bytes_used", bytes_used, 0);
      chk("arst_out_idx", strm.out_idx, 0);
      chk("arst_out_coef", strm.out_coef, 0);
      start = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;

      // fresh run after reset restarts at idx 0
      exp_push(1, 0); exp_push(3, 1);
      bq = '{8'h93, 8'h21};
      run(ETA4_SEL, 2, 2, 1'b0);

      repeat (3) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
